// File: rtl/line_burst_adaptor_pkg.sv
// Shared types for the cache-line to burst-memory adaptor: line/address shapes,
// beat indexing and FSM state encoding.
package adaptor_types;

  localparam int unsigned LINE_BITS  = 256;
  localparam int unsigned BURST_BITS = 64;
  localparam int unsigned ADDR_BITS  = 32;
  localparam int unsigned BEATS      = LINE_BITS / BURST_BITS;

  typedef logic [LINE_BITS-1:0]     line_t;
  typedef logic [ADDR_BITS-1:0]     addr_t;
  typedef logic [BURST_BITS-1:0]    burst_t;
  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

  // Legacy encodings kept so state values stay identical to the old netlist.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    RD_BURST = ST_RD,
    WR_BURST = ST_WR,
    DONE     = ST_DONE
  } adaptor_state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Turns one cache-line read/write from the arbiter into a BEATS-beat burst on
// the 64-bit physical-memory port, answering with a one-cycle line_resp.
module line_burst_adaptor
  import adaptor_types::*;
#(
  parameter int unsigned LINE_W  = $bits(line_t),
  parameter int unsigned BURST_W = $bits(burst_t),
  parameter int unsigned ADDR_W  = $bits(addr_t)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               line_resp,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  adaptor_state_t      state;
  beat_idx_t           count;
  logic [LINE_W-1:0]   line_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                last_beat;

  assign last_beat = (count == beat_idx_t'(BEATS - 1));

  // line_q doubles as the read assembly buffer and the write staging buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (write_i) begin
            line_q <= line_i;
            addr_q <= address_i;
            state  <= WR_BURST;
          end else if (read_i) begin
            addr_q <= address_i;
            state  <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_q[BURST_W*count +: BURST_W] <= burst_i;
            count <= count + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            count <= count + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign line_o    = line_q;
  assign read_o    = (state == RD_BURST);
  assign write_o   = (state == WR_BURST);
  assign line_resp = (state == DONE);
  assign address_o = {addr_q[ADDR_W-1:5], 5'b0};
  assign burst_o   = write_o ? line_q[BURST_W*count +: BURST_W] : '0;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: a per-cycle vector table plus
// hand-written back-to-back and mid-burst reset sequences.
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, line_resp;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int checks;
  int failures;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  line_burst_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_resp(line_resp),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd, wr, rsp;
    logic [63:0]  bi;
    logic [255:0] li;
    logic [31:0]  ai;
    logic         erd, ewr, elr;
    logic [63:0]  ebo;
    logic [31:0]  eao;
    logic         cl;
    logic [255:0] eline;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rd, wr, rsp, input logic [63:0] bi,
                              input logic [255:0] li, input logic [31:0] ai,
                              input logic erd, ewr, elr, input logic [63:0] ebo,
                              input logic [31:0] eao, input logic cl,
                              input logic [255:0] eline);
    vec_t t;
    t.rd = rd; t.wr = wr; t.rsp = rsp; t.bi = bi; t.li = li; t.ai = ai;
    t.erd = erd; t.ewr = ewr; t.elr = elr; t.ebo = ebo; t.eao = eao;
    t.cl = cl; t.eline = eline;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, wr, rsp, input logic [63:0] bi);
    read_i = rd; write_i = wr; resp_i = rsp; burst_i = bi;
  endtask

  logic [63:0]  r1, r2, r3, r4, wa, wb, wc, wd, jk, g0, g1, g2, g3, p0, p1, p2, p3;
  logic [255:0] wl, pl, l3;
  logic [63:0]  bb[4];
  logic [63:0]  kb[4];
  int           n;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    resp_i = 1'b0; burst_i = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_read_o",    256'(read_o),    256'd0);
    chk("rst_write_o",   256'(write_o),   256'd0);
    chk("rst_line_resp", 256'(line_resp), 256'd0);
    chk("rst_line_o",    line_o,          256'd0);
    chk("rst_burst_o",   256'(burst_o),   256'd0);
    chk("rst_address_o", 256'(address_o), 256'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    r1 = 64'h1111_1111_1111_1111; r2 = 64'h2222_2222_2222_2222;
    r3 = 64'h3333_3333_3333_3333; r4 = 64'h4444_4444_4444_4444;
    wa = 64'hAAAA_AAAA_AAAA_AAAA; wb = 64'hBBBB_BBBB_BBBB_BBBB;
    wc = 64'hCCCC_CCCC_CCCC_CCCC; wd = 64'hDDDD_DDDD_DDDD_DDDD;
    wl = {wd, wc, wb, wa};
    jk = 64'hDEAD_BEEF_DEAD_BEEF;
    g0 = 64'h1000_0000_0000_0001; g1 = 64'h2000_0000_0000_0002;
    g2 = 64'h3000_0000_0000_0003; g3 = 64'h4000_0000_0000_0004;
    p0 = 64'h0A0A_0000_0000_0010; p1 = 64'h0B0B_0000_0000_0020;
    p2 = 64'h0C0C_0000_0000_0030; p3 = 64'h0D0D_0000_0000_0040;
    pl = {p3, p2, p1, p0};

    // read, no gaps
    add(T,F,F, 64'h0, '0, 32'h0000_1234, T,F,F, 64'h0, 32'h0000_1220, F, '0);
    add(T,F,T, r1,    '0, 32'h0000_1234, T,F,F, 64'h0, 32'h0000_1220, F, '0);
    add(T,F,T, r2,    '0, 32'h0000_1234, T,F,F, 64'h0, 32'h0000_1220, F, '0);
    add(T,F,T, r3,    '0, 32'h0000_1234, T,F,F, 64'h0, 32'h0000_1220, F, '0);
    add(T,F,T, r4,    '0, 32'h0000_1234, F,F,T, 64'h0, 32'h0000_1220, T, {r4, r3, r2, r1});
    add(F,F,F, 64'h0, '0, 32'h0000_1234, F,F,F, 64'h0, 32'h0000_1220, T, {r4, r3, r2, r1});
    // write
    add(F,T,F, 64'h0, wl, 32'h0000_2008, F,T,F, wa,    32'h0000_2000, F, '0);
    add(F,T,T, 64'h0, wl, 32'h0000_2008, F,T,F, wb,    32'h0000_2000, F, '0);
    add(F,T,T, 64'h0, wl, 32'h0000_2008, F,T,F, wc,    32'h0000_2000, F, '0);
    add(F,T,T, 64'h0, wl, 32'h0000_2008, F,T,F, wd,    32'h0000_2000, F, '0);
    add(F,T,T, 64'h0, wl, 32'h0000_2008, F,F,T, 64'h0, 32'h0000_2000, F, '0);
    add(F,F,F, 64'h0, wl, 32'h0000_2008, F,F,F, 64'h0, 32'h0000_2000, F, '0);
    // gapped read 1,0,0,1,1,0,1 with junk on the bus during gaps
    add(T,F,F, jk, '0, 32'h0000_0100, T,F,F, 64'h0, 32'h0000_0100, F, '0);
    add(T,F,T, g0, '0, 32'h0000_0100, T,F,F, 64'h0, 32'h0000_0100, F, '0);
    add(T,F,F, jk, '0, 32'h0000_0100, T,F,F, 64'h0, 32'h0000_0100, F, '0);
    add(T,F,F, jk, '0, 32'h0000_0100, T,F,F, 64'h0, 32'h0000_0100, F, '0);
    add(T,F,T, g1, '0, 32'h0000_0100, T,F,F, 64'h0, 32'h0000_0100, F, '0);
    add(T,F,T, g2, '0, 32'h0000_0100, T,F,F, 64'h0, 32'h0000_0100, F, '0);
    add(T,F,F, jk, '0, 32'h0000_0100, T,F,F, 64'h0, 32'h0000_0100, F, '0);
    add(T,F,T, g3, '0, 32'h0000_0100, F,F,T, 64'h0, 32'h0000_0100, T, {g3, g2, g1, g0});
    add(F,F,F, jk, '0, 32'h0000_0100, F,F,F, 64'h0, 32'h0000_0100, T, {g3, g2, g1, g0});
    // resp_i while idle must not disturb anything
    add(F,F,T, jk, '0, 32'h0000_0100, F,F,F, 64'h0, 32'h0000_0100, T, {g3, g2, g1, g0});
    // read and write together: write wins
    add(T,T,F, 64'h0, pl, 32'h0000_0315, F,T,F, p0,    32'h0000_0300, F, '0);
    add(T,T,T, 64'h0, pl, 32'h0000_0315, F,T,F, p1,    32'h0000_0300, F, '0);
    add(T,T,T, 64'h0, pl, 32'h0000_0315, F,T,F, p2,    32'h0000_0300, F, '0);
    add(T,T,T, 64'h0, pl, 32'h0000_0315, F,T,F, p3,    32'h0000_0300, F, '0);
    add(T,T,T, 64'h0, pl, 32'h0000_0315, F,F,T, 64'h0, 32'h0000_0300, F, '0);
    add(F,F,F, 64'h0, pl, 32'h0000_0315, F,F,F, 64'h0, 32'h0000_0300, F, '0);

    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].rsp, tbl[i].bi);
      line_i = tbl[i].li; address_i = tbl[i].ai;
      cyc();
      chk($sformatf("v%0d_read_o", i),    256'(read_o),    256'(tbl[i].erd));
      chk($sformatf("v%0d_write_o", i),   256'(write_o),   256'(tbl[i].ewr));
      chk($sformatf("v%0d_line_resp", i), 256'(line_resp), 256'(tbl[i].elr));
      chk($sformatf("v%0d_burst_o", i),   256'(burst_o),   256'(tbl[i].ebo));
      chk($sformatf("v%0d_address_o", i), 256'(address_o), 256'(tbl[i].eao));
      if (tbl[i].cl) chk($sformatf("v%0d_line_o", i), line_o, tbl[i].eline);
    end

    // back-to-back: request held through DONE is not taken there
    for (int k = 0; k < 4; k++) bb[k] = 64'hB0B0_0000_0000_0000 | 64'(k);
    address_i = 32'h0000_0080;
    drive(T, F, F, 64'h0);
    cyc();
    chk("b2b_first_accept", 256'(address_o), 256'h80);
    for (int k = 0; k < 4; k++) begin
      drive(T, F, T, bb[k]);
      cyc();
    end
    chk("b2b_first_resp", 256'(line_resp), 256'd1);
    address_i = 32'h0000_0040;
    drive(T, F, F, 64'h0);
    cyc();
    chk("b2b_done_no_accept_rd", 256'(read_o),    256'd0);
    chk("b2b_done_no_accept_lr", 256'(line_resp), 256'd0);
    chk("b2b_done_no_latch",     256'(address_o), 256'h80);
    cyc();
    chk("b2b_second_read_o",  256'(read_o),    256'd1);
    chk("b2b_second_address", 256'(address_o), 256'h40);
    n = 0;
    while (n < 16) begin
      drive(T, F, T, (n < 4) ? bb[3-n] : jk);
      cyc();
      n++;
      if (line_resp) break;
    end
    chk("b2b_second_resp",  256'(line_resp), 256'd1);
    chk("b2b_second_beats", 256'(n),         256'd4);
    chk("b2b_second_line",  line_o,          {bb[0], bb[1], bb[2], bb[3]});
    drive(F, F, F, 64'h0);
    cyc();

    // reset in the middle of a write burst
    l3 = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
          64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    line_i = l3; address_i = 32'h0000_0500;
    drive(F, T, F, 64'h0);
    cyc();
    drive(F, T, T, 64'h0);
    cyc();
    cyc();
    chk("mid_write_beat2", 256'(burst_o), 256'h5555_0000_0000_0002);
    rst = 1'b0;
    #1;
    chk("rst_mid_write_o",   256'(write_o),   256'd0);
    chk("rst_mid_read_o",    256'(read_o),    256'd0);
    chk("rst_mid_line_resp", 256'(line_resp), 256'd0);
    chk("rst_mid_burst_o",   256'(burst_o),   256'd0);
    chk("rst_mid_address_o", 256'(address_o), 256'd0);
    chk("rst_mid_line_o",    line_o,          256'd0);
    drive(F, F, F, 64'h0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_idle_resp", 256'(line_resp), 256'd0);
    chk("post_rst_idle_wr",   256'(write_o),   256'd0);

    for (int k = 0; k < 4; k++) kb[k] = 64'hC0C0_0000_0000_0000 | 64'(k + 8);
    address_i = 32'h0000_061F;
    drive(T, F, F, 64'h0);
    cyc();
    chk("post_rst_read_o",  256'(read_o),    256'd1);
    chk("post_rst_address", 256'(address_o), 256'h600);
    for (int k = 0; k < 4; k++) begin
      drive(T, F, T, kb[k]);
      cyc();
      if (k < 3) chk($sformatf("post_rst_no_early_resp%0d", k), 256'(line_resp), 256'd0);
    end
    chk("post_rst_resp", 256'(line_resp), 256'd1);
    chk("post_rst_line", line_o, {kb[3], kb[2], kb[1], kb[0]});
    drive(F, F, F, 64'h0);
    cyc();
    chk("post_rst_resp_one_cycle", 256'(line_resp), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
